// File: rtl/evt_counter_pkg.sv
// Shared types and the per-channel next-count rule for the event counter bank.
package evt_counter_pkg;

   // Modulus every channel uses out of reset until software writes its own.
   localparam int DEFAULT_MAX_C = 115200;

   // Width the next-count helper computes in; channel WIDTH must not exceed it.
   localparam int CALC_W = 32;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   typedef struct packed {
      logic [CALC_W-1:0] count;
      logic              wrap;
   } next_t;

   // Value a channel moves to on one event, plus whether that event wraps.
   // A modulus of 0 or 1 collapses the range to the single value 0.
   function automatic next_t next_count(input logic [CALC_W-1:0] count,
                                        input logic [CALC_W-1:0] m,
                                        input dir_e              dir);
      next_t             res;
      logic [CALC_W-1:0] last;
      // NOTE: blocking '=' inside functions and always_comb; each line sees the value computed by the previous one.
      last      = (m <= 1) ? '0 : m - 1'b1;
      res.count = count;
      res.wrap  = 1'b0;
      if (dir == DIR_UP) begin
         if (count >= last) begin
            res.count = '0;
            res.wrap  = 1'b1;
         end else begin
            res.count = count + 1'b1;
         end
      end else begin
         if (count == '0) begin
            res.count = last;
            res.wrap  = 1'b1;
         end else if (count > last) begin
            // Modulus shrank below the current count: clamp without wrapping.
            res.count = last;
         end else begin
            res.count = count - 1'b1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/evt_counter_chan.sv
// One modulo event counter channel: modulus, count and wrap registers with
// clear > load > event priority and a combinational wrap for cascading.
module evt_counter_chan
   import evt_counter_pkg::*;
#(
   parameter int WIDTH       = 17,
   parameter int DEFAULT_MAX = DEFAULT_MAX_C
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             evt_in,
   input  dir_e             dir_in,
   input  logic             clr_in,
   input  logic             load_in,
   input  logic [WIDTH-1:0] load_val_in,
   input  logic             max_we_in,
   input  logic [WIDTH-1:0] max_in,
   output logic [WIDTH-1:0] count_out,
   output logic             wrap_out,
   output logic             wrap_evt_out
);

   logic [WIDTH-1:0] modulus;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] load_cnt;
   logic             wrap_q;
   logic             wrap_evt;
   next_t            nxt;

   // Next count, same-cycle wrap (suppressed by clear/load) and clamped load value.
   always_comb begin
      // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
      nxt      = next_count(CALC_W'(count), CALC_W'(modulus), dir_in);
      wrap_evt = evt_in & ~clr_in & ~load_in & nxt.wrap;
      load_cnt = (load_val_in < modulus) ? load_val_in : '0;
   end

   // Modulus, count and registered wrap pulse; the modulus update takes effect next cycle.
   always_ff @(posedge clk_in) begin
      // NOTE: sequential state uses non-blocking '<=' so all registers update from pre-edge values.
      if (rst_in) begin
         count   <= '0;
         wrap_q  <= 1'b0;
         // NOTE: the modulus is a plain register, not a memory, so it is reset to a known value.
         modulus <= WIDTH'(DEFAULT_MAX);
      end else begin
         wrap_q <= wrap_evt;
         if (max_we_in) begin
            modulus <= max_in;
         end
         if (clr_in) begin
            count <= '0;
         end else if (load_in) begin
            count <= load_cnt;
         end else if (evt_in) begin
            count <= nxt.count[WIDTH-1:0];
         end
      end
   end

   // The helper works in CALC_W bits; the bits above WIDTH are always zero here.
   if (WIDTH < CALC_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = |nxt.count[CALC_W-1:WIDTH];
   end

   assign count_out    = count;
   assign wrap_out     = wrap_q;
   assign wrap_evt_out = wrap_evt;

endmodule

// File: rtl/evt_counter_bank.sv
// Bank of independent modulo event counters; channel i may count on channel
// i-1's same-cycle wrap, so cascaded chains ripple within one clock.
module evt_counter_bank
   import evt_counter_pkg::*;
#(
   parameter int CHANNELS    = 4,
   parameter int WIDTH       = 17,
   parameter int DEFAULT_MAX = DEFAULT_MAX_C
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic [CHANNELS-1:0]       evt_in,
   input  logic [CHANNELS-1:0]       dir_in,
   input  logic [CHANNELS-1:0]       cascade_in,
   input  logic [CHANNELS-1:0]       clr_in,
   input  logic [CHANNELS-1:0]       load_in,
   input  logic [CHANNELS*WIDTH-1:0] load_val_in,
   input  logic [CHANNELS-1:0]       max_we_in,
   input  logic [CHANNELS*WIDTH-1:0] max_in,
   output logic [CHANNELS*WIDTH-1:0] count_out,
   output logic [CHANNELS-1:0]       wrap_out
);

   // Channel 0 has no predecessor, so its cascade select is meaningless.
   logic unused_cascade0;
   assign unused_cascade0 = cascade_in[0];

   for (genvar i = 0; i < CHANNELS; i++) begin : chan_g
      logic ev;
      logic wrap_evt;

      if (i == 0) begin : g_first
         assign ev = evt_in[0];
      end else begin : g_casc
         assign ev = cascade_in[i] ? chan_g[i-1].wrap_evt : evt_in[i];
      end

      evt_counter_chan #(
         .WIDTH       (WIDTH),
         .DEFAULT_MAX (DEFAULT_MAX)
      ) u_chan (
         .clk_in       (clk_in),
         .rst_in       (rst_in),
         .evt_in       (ev),
         .dir_in       (dir_e'(dir_in[i])),
         .clr_in       (clr_in[i]),
         .load_in      (load_in[i]),
         .load_val_in  (load_val_in[i*WIDTH +: WIDTH]),
         .max_we_in    (max_we_in[i]),
         .max_in       (max_in[i*WIDTH +: WIDTH]),
         .count_out    (count_out[i*WIDTH +: WIDTH]),
         .wrap_out     (wrap_out[i]),
         .wrap_evt_out (wrap_evt)
      );
   end

endmodule

// File: tb/tb_evt_counter_bank.sv
// Scoreboard bench for evt_counter_bank: stimulus pushes model predictions,
// a monitor compares them against the DUT one cycle later.
module tb_evt_counter_bank;

   localparam int CH   = 4;
   localparam int W    = 17;
   localparam int DMAX = 115200;

   logic            clk_in = 1'b0;
   logic            rst_in;
   logic [CH-1:0]   evt_in, dir_in, cascade_in, clr_in, load_in, max_we_in;
   logic [CH*W-1:0] load_val_in, max_in, count_out;
   logic [CH-1:0]   wrap_out;

   always #5 clk_in = ~clk_in;

   evt_counter_bank #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_MAX(DMAX)) dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .evt_in      (evt_in),
      .dir_in      (dir_in),
      .cascade_in  (cascade_in),
      .clr_in      (clr_in),
      .load_in     (load_in),
      .load_val_in (load_val_in),
      .max_we_in   (max_we_in),
      .max_in      (max_in),
      .count_out   (count_out),
      .wrap_out    (wrap_out)
   );

   int vectors     = 0;
   int miscompares = 0;

   logic [CH*W-1:0] exp_cnt_q[$];
   logic [CH-1:0]   exp_wrap_q[$];
   string           tag_q[$];

   // Reference model state: plain integer count and modulus per channel.
   int mdl_cnt[CH];
   int mdl_mod[CH];

   task automatic check(input string name,
                        input logic [CH*W-1:0] act_c, input logic [CH*W-1:0] exp_c,
                        input logic [CH-1:0] act_w, input logic [CH-1:0] exp_w);
      vectors++;
      if (act_c !== exp_c || act_w !== exp_w) begin
         miscompares++;
         $display("FAIL %s: counts(ch3..ch0)=%0d,%0d,%0d,%0d wrap=%b, expected %0d,%0d,%0d,%0d wrap=%b",
                  name, act_c[3*W +: W], act_c[2*W +: W], act_c[W +: W], act_c[0 +: W], act_w,
                  exp_c[3*W +: W], exp_c[2*W +: W], exp_c[W +: W], exp_c[0 +: W], exp_w);
      end
   endtask

   task automatic idle();
      rst_in      = 1'b0;
      evt_in      = '0;
      dir_in      = '0;
      cascade_in  = '0;
      clr_in      = '0;
      load_in     = '0;
      load_val_in = '0;
      max_we_in   = '0;
      max_in      = '0;
   endtask

   // Advance the model by one clock using the inputs currently driven, queue the
   // expected outputs, then let the DUT take that edge.
   task automatic apply(input string tag);
      logic [CH*W-1:0] ec;
      logic [CH-1:0]   w;
      w  = '0;
      ec = '0;
      if (rst_in) begin
         for (int i = 0; i < CH; i++) begin
            mdl_cnt[i] = 0;
            mdl_mod[i] = DMAX;
         end
      end else begin
         for (int i = 0; i < CH; i++) begin
            int m, lim, c, lv;
            logic ev;
            m   = mdl_mod[i];
            lim = (m <= 1) ? 0 : m - 1;
            c   = mdl_cnt[i];
            lv  = int'(load_val_in[i*W +: W]);
            ev  = (i > 0 && cascade_in[i]) ? w[i-1] : evt_in[i];
            if (clr_in[i]) c = 0;
            else if (load_in[i]) c = (lv < m) ? lv : 0;
            else if (ev) begin
               if (!dir_in[i]) begin
                  if (c >= lim) begin c = 0; w[i] = 1'b1; end
                  else c = c + 1;
               end else begin
                  if (c == 0) begin c = lim; w[i] = 1'b1; end
                  else if (c > lim) c = lim;
                  else c = c - 1;
               end
            end
            mdl_cnt[i] = c;
            if (max_we_in[i]) mdl_mod[i] = int'(max_in[i*W +: W]);
         end
      end
      for (int i = 0; i < CH; i++) ec[i*W +: W] = W'(mdl_cnt[i]);
      exp_cnt_q.push_back(ec);
      exp_wrap_q.push_back(w);
      tag_q.push_back(tag);
      @(negedge clk_in);
   endtask

   // Monitor: registered outputs are sampled just after each rising edge.
   initial begin
      forever begin
         @(posedge clk_in);
         #1;
         if (exp_cnt_q.size() > 0)
            check(tag_q.pop_front(), count_out, exp_cnt_q.pop_front(),
                  wrap_out, exp_wrap_q.pop_front());
      end
   end

   initial begin
      idle();
      @(negedge clk_in);

      // Reset, then ch0 modulus 4 counting up every cycle.
      rst_in = 1'b1; apply("reset");
      apply("reset_hold");
      idle(); max_we_in[0] = 1'b1; max_in[0 +: W] = W'(4); apply("m4_write");
      idle(); evt_in[0] = 1'b1;
      repeat (9) apply("up_m4");

      // ch1 cascaded on ch0, both modulus 10, 100 events into ch0.
      idle(); clr_in = '1; max_we_in[1:0] = 2'b11;
      max_in[0 +: W] = W'(10); max_in[W +: W] = W'(10); apply("cascade_setup");
      idle(); evt_in[0] = 1'b1; cascade_in[1] = 1'b1;
      repeat (100) apply("cascade_m10");

      // ch2 counting down from reset with modulus 5.
      idle(); rst_in = 1'b1; apply("reset2");
      idle(); max_we_in[2] = 1'b1; max_in[2*W +: W] = W'(5); dir_in[2] = 1'b1; apply("m5_write");
      idle(); evt_in[2] = 1'b1; dir_in[2] = 1'b1;
      repeat (3) apply("down_m5");

      // ch3 load clamping, load beating an event, clear suppressing a wrap.
      idle(); max_we_in[3] = 1'b1; max_in[3*W +: W] = W'(8); apply("m8_write");
      idle(); load_in[3] = 1'b1; load_val_in[3*W +: W] = W'(12); apply("load_over_max");
      idle(); load_in[3] = 1'b1; evt_in[3] = 1'b1; load_val_in[3*W +: W] = W'(6); apply("load_with_evt");
      idle(); evt_in[3] = 1'b1; apply("up_to_7");
      idle(); clr_in[3] = 1'b1; evt_in[3] = 1'b1; apply("clr_at_top");
      idle(); apply("idle_after_clr");

      // ch0 modulus shrink under a down event, then modulus 1.
      idle(); max_we_in[0] = 1'b1; max_in[0 +: W] = W'(10); apply("m10_write");
      idle(); load_in[0] = 1'b1; load_val_in[0 +: W] = W'(9); apply("load9");
      idle(); max_we_in[0] = 1'b1; max_in[0 +: W] = W'(3); apply("shrink_to_3");
      idle(); evt_in[0] = 1'b1; dir_in[0] = 1'b1; apply("down_after_shrink");
      idle(); max_we_in[0] = 1'b1; max_in[0 +: W] = W'(1); apply("m1_write");
      idle(); evt_in[0] = 1'b1;
      repeat (4) apply("m1_events");
      idle(); max_we_in[0] = 1'b1; max_in[0 +: W] = W'(0); evt_in[0] = 1'b1; apply("m0_write");
      repeat (2) apply("m0_events");

      // Mid-count reset with events pending, then default modulus boundary.
      idle(); max_we_in = '1;
      for (int i = 0; i < CH; i++) max_in[i*W +: W] = W'(7);
      apply("m7_all");
      idle(); evt_in = '1;
      repeat (5) apply("run_all");
      rst_in = 1'b1; apply("mid_reset");
      idle(); load_in[1:0] = 2'b11;
      load_val_in[0 +: W] = W'(DMAX - 3); load_val_in[W +: W] = W'(DMAX); apply("load_default_edge");
      idle(); evt_in[0] = 1'b1;
      repeat (3) apply("default_wrap");

      // Randomised traffic across all channels.
      for (int n = 0; n < 3000; n++) begin
         idle();
         rst_in = ($urandom_range(199) == 0);
         for (int i = 0; i < CH; i++) begin
            evt_in[i]     = ($urandom_range(3) != 0);
            dir_in[i]     = 1'($urandom_range(1));
            cascade_in[i] = 1'($urandom_range(1));
            clr_in[i]     = ($urandom_range(23) == 0);
            load_in[i]    = ($urandom_range(15) == 0);
            max_we_in[i]  = ($urandom_range(9) == 0);
            load_val_in[i*W +: W] = ($urandom_range(7) == 0) ? W'($urandom_range(2**W - 1))
                                                              : W'($urandom_range(15));
            max_in[i*W +: W]      = ($urandom_range(7) == 0) ? W'($urandom_range(2**W - 1))
                                                              : W'($urandom_range(12));
         end
         apply("random");
      end
      idle();

      for (int k = 0; k < 5 && exp_cnt_q.size() > 0; k++) @(negedge clk_in);
      if (exp_cnt_q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected responses never compared, expected 0", exp_cnt_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/evt_counter_bank.md
Name: evt_counter_bank

Overview:
Bank of CHANNELS independent, parametrised modulo event counters. It generalises the single fixed-modulus baud/event counter. Each channel adds:
- a runtime modulus
- up/down direction
- synchronous clear and load
- a registered wrap pulse
- optional cascading onto the previous channel's wrap, forming multi-digit counters (e.g. timers, sample/frame counters in the audio and UART paths).

Parameters:
CHANNELS, 4, number of counter channels
WIDTH, 17, bit width of each count and modulus
DEFAULT_MAX, 115200, modulus used after reset until the channel's max_in is written (max_we_in)

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous reset, active-high
evt_in  input  CHANNELS  per-channel event strobe, one count per cycle high
dir_in  input  CHANNELS  per-channel direction: 0 = up, 1 = down
cascade_in  input  CHANNELS  1 = channel i counts on channel i-1's internal wrap instead of evt_in[i]; bit 0 ignored
clr_in  input  CHANNELS  per-channel synchronous clear to 0
load_in  input  CHANNELS  per-channel synchronous load of load_val_in slice
load_val_in  input  CHANNELS*WIDTH  packed load values, channel i at [i*WIDTH +: WIDTH]
max_we_in  input  CHANNELS  per-channel modulus write strobe
max_in  input  CHANNELS*WIDTH  packed modulus values M (count range 0..M-1)
count_out  output  CHANNELS*WIDTH  packed current counts, registered
wrap_out  output  CHANNELS  registered one-cycle wrap pulse per channel

Behaviour:
Reset (rst_in=1 at clk edge):
- all count slices <= 0
- all wrap_out <= 0
- all stored moduli <= DEFAULT_MAX
- reset overrides every other input

Per-channel priority each edge: clr_in > load_in > count event. Modulus write (max_we_in) is independent and may coincide with any of them.

Modulus handling:
- The stored modulus updates on max_we_in at the edge.
- Counting in the same cycle uses the old modulus.
- Effective modulus M<=1: count held at 0 and every event is a wrap.

Effective event for channel i:
- ev_i = (i>0 && cascade_in[i]) ? wrap_evt_{i-1} : evt_in[i]
- wrap_evt is combinational, same cycle, so a cascade ripples through all channels in one clock with no added latency.

Up (dir=0), on ev:
- count >= M-1 → count <= 0, wrap_evt=1
- else count <= count+1

Down (dir=1), on ev:
- count == 0 → count <= M-1, wrap_evt=1
- count > M-1 (modulus shrank) → count <= M-1, wrap_evt=0
- else count <= count-1

Suppression: clr_in or load_in active on a channel forces that channel's wrap_evt=0. This also blocks the cascade into the next channel.

Load: count <= load_val if load_val < M, else count <= 0.

wrap_out[i]:
- registered copy of wrap_evt_i, high exactly the cycle after the wrapping edge (i.e. coincident with count_out showing the wrapped value)
- no wrap_out on clear, load or reset

Arithmetic: all compares unsigned, WIDTH bits; M-1 computed in WIDTH bits with the M<=1 guard. No output ever exceeds max(M-1,0) except transiently after a modulus decrease with no event.

Mid-operation reset: counts return to 0 and moduli to DEFAULT_MAX the next cycle regardless of pending events; wrap_out is 0 that cycle.

Decomposition:
- Package evt_counter_pkg:
  - dir_e enum (DIR_UP=0, DIR_DOWN=1)
  - localparam for the default modulus
  - function next_count(count, M, dir) returning next value and wrap flag
- Sub-module evt_counter_chan: one channel (modulus reg, count reg, wrap reg, priority logic), exposes a combinational wrap_evt for cascading.
- evt_counter_bank generates CHANNELS instances and wires the cascade mux.

Test Plan:
- Reset then M=4 on ch0 (max_we), up, evt every cycle for 9 cycles → count 1,2,3,0,1,2,3,0,1; wrap_out[0] high on the cycles count shows 0.
- ch1 cascade_in=1, both M=10, ch0 evt continuous for 100 cycles → ch1=9,ch0=9 after 99 events; event 100 → both 0, wrap_out[0] and wrap_out[1] high same cycle.
- ch2 down, M=5, from reset, 3 events → counts 4 (wrap_out=1), 3, 2.
- ch3 M=8, load_val=12 with load_in → count 0; load_val=6 with load_in and evt_in same cycle → 6, no wrap; clr_in with evt at count 7 → 0, wrap_out stays 0.
- ch0 count=9 with M=10, write M=3 then down event → count 2, no wrap; M=1 with evt each cycle → count stays 0, wrap_out high every cycle.
- rst_in asserted mid-count (counts nonzero, evt active) → next cycle all counts 0, wrap_out 0, moduli DEFAULT_MAX (ch0 counts to 115199 before wrapping).
